// File: rtl/plm_pkg.sv
// ============================================================================
// Module  : plm_pkg
// Purpose : Shared widths, command field extraction and pipeline stage type
//           for the PLM bank responder and the scheduling kernel.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package plm_pkg;

  localparam int ADDR_WIDTH       = 4;
  localparam int VALUE_WIDTH      = 8;
  localparam int NCONSUMERS       = 2;
  localparam int NBANKS           = 1;
  localparam int NPORTS           = 2;

  localparam int BANK_SEL_WIDTH   = $clog2(NBANKS);
  localparam int LOCAL_ADDR_WIDTH = ADDR_WIDTH - BANK_SEL_WIDTH;
  localparam int NKERNELS         = NBANKS * NPORTS;
  localparam int TAG_WIDTH        = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int CMD_WIDTH        = LOCAL_ADDR_WIDTH + VALUE_WIDTH + 1;
  localparam int MEM_DEPTH        = 1 << LOCAL_ADDR_WIDTH;

  typedef logic [LOCAL_ADDR_WIDTH-1:0] laddr_t;
  typedef logic [VALUE_WIDTH-1:0]      value_t;
  typedef logic [TAG_WIDTH-1:0]        tag_t;
  typedef logic [CMD_WIDTH-1:0]        cmd_t;

  typedef struct packed {
    logic   valid;
    tag_t   tag;
    logic   we;
    value_t data;
  } pipe_stage_t;

  // Command layout, MSB to LSB: {local addr, value, we}
  function automatic laddr_t cmd_addr(input cmd_t c);
    return c[CMD_WIDTH-1 -: LOCAL_ADDR_WIDTH];
  endfunction

  function automatic value_t cmd_value(input cmd_t c);
    return c[VALUE_WIDTH:1];
  endfunction

  function automatic logic cmd_we(input cmd_t c);
    return c[0];
  endfunction

  function automatic logic tag_in_range(input tag_t t);
    return int'(t) < NCONSUMERS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plm_bank_mem.sv
// ============================================================================
// Module  : plm_bank_mem
// Purpose : One NPORTS-port memory bank, read-before-write, lowest port wins
//           on same-address writes. Conflict output only with
//           PLM_RESP_COLLISION_CHECK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module plm_bank_mem
  import plm_pkg::*;
(
  input  logic                  clk,
  input  logic   [NPORTS-1:0]   en,
  input  logic   [NPORTS-1:0]   we,
  input  laddr_t [NPORTS-1:0]   addr,
  input  value_t [NPORTS-1:0]   wdata,
  output value_t [NPORTS-1:0]   rdata
`ifdef PLM_RESP_COLLISION_CHECK_EN
  ,
  output logic                  conflict
`endif
);

  value_t mem_q [MEM_DEPTH];
  value_t mem_d [MEM_DEPTH];

  // Walking from the highest port down lets the lowest port's write land last
  always_comb begin
    mem_d = mem_q;
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (en[p] && we[p]) begin
        mem_d[addr[p]] = wdata[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rdata[p] = mem_q[addr[p]];
    end
  end

`ifdef PLM_RESP_COLLISION_CHECK_EN
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int r = p + 1; r < NPORTS; r++) begin
        if (en[p] && we[p] && en[r] && we[r] && (addr[p] == addr[r])) begin
          conflict = 1'b1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/plm_bank_responder.sv
// ============================================================================
// Module  : plm_bank_responder
// Purpose : Executes scheduler PLM commands on banked memory and routes
//           read-data / write-ack responses to consumers after READ_LATENCY.
//           Optional macro: PLM_RESP_COLLISION_CHECK_EN (sticky collision).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module plm_bank_responder
  import plm_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  cmd_t   [NKERNELS-1:0]     cmd,
  input  logic   [NKERNELS-1:0]     cmd_valid,
  input  tag_t   [NKERNELS-1:0]     cmd_tag,
  output logic   [NCONSUMERS-1:0]   resp_valid,
  output logic   [NCONSUMERS-1:0]   resp_write,
  output value_t [NCONSUMERS-1:0]   resp_data,
  output logic                      collision
);

  laddr_t [NKERNELS-1:0] addr_k;
  value_t [NKERNELS-1:0] wdata_k;
  logic   [NKERNELS-1:0] we_k;
  value_t [NKERNELS-1:0] rdata_k;

  for (genvar k = 0; k < NKERNELS; k++) begin : g_fields
    assign addr_k[k]  = cmd_addr(cmd[k]);
    assign wdata_k[k] = cmd_value(cmd[k]);
    assign we_k[k]    = cmd_we(cmd[k]);
  end

`ifdef PLM_RESP_COLLISION_CHECK_EN
  logic [NBANKS-1:0] bank_conflict;
`endif

  // Port k belongs to bank k / NPORTS
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    plm_bank_mem u_bank (
      .clk      (clk),
      .en       (cmd_valid[b*NPORTS +: NPORTS]),
      .we       (we_k[b*NPORTS +: NPORTS]),
      .addr     (addr_k[b*NPORTS +: NPORTS]),
      .wdata    (wdata_k[b*NPORTS +: NPORTS]),
      .rdata    (rdata_k[b*NPORTS +: NPORTS])
`ifdef PLM_RESP_COLLISION_CHECK_EN
      ,
      .conflict (bank_conflict[b])
`endif
    );
  end

  // Stage 0 captures the pre-write read data at the command edge
  pipe_stage_t pipe_q [READ_LATENCY][NKERNELS];
  pipe_stage_t pipe_d [READ_LATENCY][NKERNELS];

  always_comb begin
    for (int k = 0; k < NKERNELS; k++) begin
      pipe_d[0][k].valid = cmd_valid[k];
      pipe_d[0][k].tag   = cmd_tag[k];
      pipe_d[0][k].we    = we_k[k];
      pipe_d[0][k].data  = we_k[k] ? '0 : rdata_k[k];
    end
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        for (int k = 0; k < NKERNELS; k++) begin
          pipe_q[s][k] <= '0;
        end
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  logic   [NCONSUMERS-1:0] resp_valid_d, resp_valid_q;
  logic   [NCONSUMERS-1:0] resp_write_d, resp_write_q;
  value_t [NCONSUMERS-1:0] resp_data_d,  resp_data_q;
`ifdef PLM_RESP_COLLISION_CHECK_EN
  logic                    tag_err;
`endif

  // Tag router: first (lowest) port claiming a consumer slot wins
  always_comb begin
    resp_valid_d = '0;
    resp_write_d = '0;
    resp_data_d  = '0;
`ifdef PLM_RESP_COLLISION_CHECK_EN
    tag_err      = 1'b0;
`endif
    for (int k = 0; k < NKERNELS; k++) begin
      if (pipe_q[READ_LATENCY-1][k].valid) begin
        if (!tag_in_range(pipe_q[READ_LATENCY-1][k].tag)) begin
`ifdef PLM_RESP_COLLISION_CHECK_EN
          tag_err = 1'b1;
`endif
        end else if (resp_valid_d[pipe_q[READ_LATENCY-1][k].tag]) begin
`ifdef PLM_RESP_COLLISION_CHECK_EN
          tag_err = 1'b1;
`endif
        end else begin
          resp_valid_d[pipe_q[READ_LATENCY-1][k].tag] = 1'b1;
          resp_write_d[pipe_q[READ_LATENCY-1][k].tag] = pipe_q[READ_LATENCY-1][k].we;
          resp_data_d[pipe_q[READ_LATENCY-1][k].tag]  = pipe_q[READ_LATENCY-1][k].data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_write_q <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_data  = resp_data_q;

`ifdef PLM_RESP_COLLISION_CHECK_EN
  logic collision_d, collision_q;

  always_comb begin
    collision_d = collision_q | (|bank_conflict) | tag_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plm_bank_responder.sv
// ============================================================================
// Module  : tb_plm_bank_responder
// Purpose : Scoreboard bench for plm_bank_responder (latency 1 and latency 3
//           instances). Honors PLM_RESP_COLLISION_CHECK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_plm_bank_responder;
  import plm_pkg::*;

`ifdef PLM_RESP_COLLISION_CHECK_EN
  localparam logic EXP_COL = 1'b1;
`else
  localparam logic EXP_COL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n, rst3_n;
  cmd_t   [NKERNELS-1:0]   cmd, cmd3;
  logic   [NKERNELS-1:0]   cmd_valid, cmd_valid3;
  tag_t   [NKERNELS-1:0]   cmd_tag, cmd_tag3;
  logic   [NCONSUMERS-1:0] rv, rw, rv3, rw3;
  value_t [NCONSUMERS-1:0] rd, rd3;
  logic                    col, col3;

  plm_bank_responder #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_tag(cmd_tag),
    .resp_valid(rv), .resp_write(rw), .resp_data(rd), .collision(col)
  );

  plm_bank_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .cmd(cmd3), .cmd_valid(cmd_valid3), .cmd_tag(cmd_tag3),
    .resp_valid(rv3), .resp_write(rw3), .resp_data(rd3), .collision(col3)
  );

  typedef struct {
    int     cyc;
    logic   w;
    value_t d;
  } exp_t;

  exp_t   q      [2][NCONSUMERS][$];
  value_t mem_m  [2][MEM_DEPTH];
  bit     taken  [2][NCONSUMERS];
  bit     wr_en  [2][NKERNELS];
  laddr_t wr_a   [2][NKERNELS];
  value_t wr_v   [2][NKERNELS];
  int     cyc    = 0;
  int     n_cmp  = 0;
  int     n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever a consumer sees resp_valid
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        logic   v, w;
        value_t dt;
        exp_t   e;
        v  = (d == 1) ? rv3[c] : rv[c];
        w  = (d == 1) ? rw3[c] : rw[c];
        dt = (d == 1) ? rd3[c] : rd[c];
        while (q[d][c].size() > 0 && q[d][c][0].cyc < cyc) begin
          e = q[d][c].pop_front();
          n_cmp++; n_bad++;
          $display("FAIL missing_resp dut%0d cons%0d: got nothing, required response at cycle %0d", d, c, e.cyc);
        end
        if (v) begin
          n_cmp++;
          if (q[d][c].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_resp dut%0d cons%0d cycle %0d: got write=%0b data=%0h, required none", d, c, cyc, w, dt);
          end else begin
            e = q[d][c].pop_front();
            if (e.cyc != cyc || w !== e.w || dt !== e.d) begin
              n_bad++;
              $display("FAIL resp dut%0d cons%0d: got cycle=%0d write=%0b data=%0h, required cycle=%0d write=%0b data=%0h",
                       d, c, cyc, w, dt, e.cyc, e.w, e.d);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drive one command; the expectation reads the model before this cycle's writes
  task automatic issue(input int d, input int k, input logic we, input int a, input int v, input int tag);
    laddr_t la;
    value_t vv;
    exp_t   e;
    la = laddr_t'(a);
    vv = value_t'(v);
    if (d == 0) begin
      cmd[k] = {la, vv, we}; cmd_valid[k] = 1'b1; cmd_tag[k] = tag_t'(tag);
    end else begin
      cmd3[k] = {la, vv, we}; cmd_valid3[k] = 1'b1; cmd_tag3[k] = tag_t'(tag);
    end
    if (!taken[d][tag]) begin
      taken[d][tag] = 1'b1;
      e.cyc = cyc + 1 + ((d == 1) ? 3 : 1);
      e.w   = we;
      e.d   = we ? '0 : mem_m[d][la];
      q[d][tag].push_back(e);
    end
    if (we) begin
      wr_en[d][k] = 1'b1; wr_a[d][k] = la; wr_v[d][k] = vv;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = NKERNELS - 1; k >= 0; k--) begin
        if (wr_en[d][k]) mem_m[d][wr_a[d][k]] = wr_v[d][k];
        wr_en[d][k] = 1'b0;
      end
      for (int c = 0; c < NCONSUMERS; c++) taken[d][c] = 1'b0;
    end
    @(negedge clk);
    cmd_valid  = '0;
    cmd_valid3 = '0;
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    cmd = '0; cmd3 = '0; cmd_valid = '0; cmd_valid3 = '0; cmd_tag = '0; cmd_tag3 = '0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NKERNELS; k++) wr_en[d][k] = 1'b0;
      for (int c = 0; c < NCONSUMERS; c++) taken[d][c] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("reset_resp_valid", 32'(rv), 0);
    chk("reset_resp_write", 32'(rw), 0);
    chk("reset_resp_data",  32'(rd), 0);
    chk("reset_collision",  32'(col), 0);
    chk("reset_resp_valid3", 32'(rv3), 0);
    rst_n = 1'b1; rst3_n = 1'b1;

    // Write then read back through consumer 1
    issue(0, 0, 1'b1, 3, 'hA5, 1); step();
    issue(0, 0, 1'b0, 3, 0, 1);    step();

    // Read-before-write on the same address
    issue(0, 0, 1'b1, 5, 'h22, 0); step();
    issue(0, 0, 1'b1, 5, 'h11, 0); issue(0, 1, 1'b0, 5, 0, 1); step();
    issue(0, 1, 1'b0, 5, 0, 1);    step();
    chk("collision_clean", 32'(col), 0);

    // Same-address write conflict: port 0 wins
    issue(0, 0, 1'b1, 7, 'h33, 0); issue(0, 1, 1'b1, 7, 'h44, 1); step();
    chk("collision_write_conflict", 32'(col), 32'(EXP_COL));
    issue(0, 0, 1'b0, 7, 0, 0); step();

    // Cross routing, then duplicate tag 0 (port 0 delivered)
    issue(0, 0, 1'b0, 3, 0, 1); issue(0, 1, 1'b0, 5, 0, 0); step();
    issue(0, 0, 1'b0, 3, 0, 0); issue(0, 1, 1'b0, 7, 0, 0); step();

    // Throughput: fill then stream back-to-back reads
    for (int a = 0; a < MEM_DEPTH; a++) begin
      issue(0, 0, 1'b1, a, (a * 37 + 9) & 'hFF, 0); step();
    end
    for (int a = 0; a < MEM_DEPTH; a++) begin
      issue(0, 0, 1'b0, a, 0, 1); step();
    end

    // Latency-3 instance: reset while a read is in flight
    issue(1, 0, 1'b1, 2, 'h5C, 0); step();
    repeat (4) step();
    issue(1, 0, 1'b0, 2, 0, 0); step();
    step();
    rst3_n = 1'b0;
    q[1][0].delete();
    #1;
    chk("midflight_reset_valid3", 32'(rv3), 0);
    chk("midflight_reset_col3",   32'(col3), 0);
    step();
    rst3_n = 1'b1;
    repeat (5) step();
    issue(1, 0, 1'b0, 2, 0, 0); step();
    repeat (5) step();

    // Sticky collision, then asynchronous clear
    chk("collision_sticky", 32'(col), 32'(EXP_COL));
    rst_n = 1'b0;
    #1;
    chk("collision_after_reset", 32'(col), 0);
    chk("resp_valid_after_reset", 32'(rv), 0);
    step();

    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        chk($sformatf("leftover_dut%0d_cons%0d", d, c), 32'(q[d][c].size()), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
